// File: rtl/rmt_path_arbiter.sv
// Two-port AXI-Stream merger with packet-granular arbitration.
// Ties go to the port that was not served last, and the master output stage is a single register slice.
module rmt_path_arbiter #(
   parameter int C_S_AXIS_DATA_WIDTH  = 512,
   parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
   input  logic                              clk,
   input  logic                              rst,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
   input  logic                              s0_axis_tvalid,
   input  logic                              s0_axis_tlast,
   output logic                              s0_axis_tready,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
   input  logic                              s1_axis_tvalid,
   input  logic                              s1_axis_tlast,
   output logic                              s1_axis_tready,

   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,

   output logic [31:0]                       pkt_cnt_0,
   output logic [31:0]                       pkt_cnt_1,
   output logic [1:0]                        cur_grant
);

   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
   localparam int TW = C_S_AXIS_TUSER_WIDTH;

   // Encodings double as the cur_grant value.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic            last_served_q, last_served_d;
   logic [DW-1:0]   m_tdata_q, m_tdata_d;
   logic [KW-1:0]   m_tkeep_q, m_tkeep_d;
   logic [TW-1:0]   m_tuser_q, m_tuser_d;
   logic            m_tvalid_q, m_tvalid_d;
   logic            m_tlast_q, m_tlast_d;
   logic [31:0]     pkt_cnt_0_q, pkt_cnt_0_d;
   logic [31:0]     pkt_cnt_1_q, pkt_cnt_1_d;

   logic            slot_free;
   logic            acc0;
   logic            acc1;

   assign slot_free      = !m_tvalid_q || m_axis_tready;
   assign s0_axis_tready = !rst && (state_q == GRANT0) && slot_free;
   assign s1_axis_tready = !rst && (state_q == GRANT1) && slot_free;
   assign acc0           = s0_axis_tvalid && s0_axis_tready;
   assign acc1           = s1_axis_tvalid && s1_axis_tready;

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      pkt_cnt_0_d   = pkt_cnt_0_q;
      pkt_cnt_1_d   = pkt_cnt_1_q;
      m_tdata_d     = m_tdata_q;
      m_tkeep_d     = m_tkeep_q;
      m_tuser_d     = m_tuser_q;
      m_tvalid_d    = m_tvalid_q;
      m_tlast_d     = m_tlast_q;

      case (state_q)
         IDLE: begin
            if (s0_axis_tvalid && s1_axis_tvalid)
               state_d = last_served_q ? GRANT0 : GRANT1;
            else if (s0_axis_tvalid)
               state_d = GRANT0;
            else if (s1_axis_tvalid)
               state_d = GRANT1;
         end
         GRANT0: begin
            if (acc0 && s0_axis_tlast) begin
               state_d       = IDLE;
               last_served_d = 1'b0;
               pkt_cnt_0_d   = pkt_cnt_0_q + 32'd1;
            end
         end
         GRANT1: begin
            if (acc1 && s1_axis_tlast) begin
               state_d       = IDLE;
               last_served_d = 1'b1;
               pkt_cnt_1_d   = pkt_cnt_1_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Only the granted port can be ready, so at most one of acc0/acc1 is set.
      if (acc0) begin
         m_tdata_d  = s0_axis_tdata;
         m_tkeep_d  = s0_axis_tkeep;
         m_tuser_d  = s0_axis_tuser;
         m_tlast_d  = s0_axis_tlast;
         m_tvalid_d = 1'b1;
      end else if (acc1) begin
         m_tdata_d  = s1_axis_tdata;
         m_tkeep_d  = s1_axis_tkeep;
         m_tuser_d  = s1_axis_tuser;
         m_tlast_d  = s1_axis_tlast;
         m_tvalid_d = 1'b1;
      end else if (slot_free) begin
         m_tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         last_served_q <= 1'b1;
         m_tdata_q     <= '0;
         m_tkeep_q     <= '0;
         m_tuser_q     <= '0;
         m_tvalid_q    <= 1'b0;
         m_tlast_q     <= 1'b0;
         pkt_cnt_0_q   <= '0;
         pkt_cnt_1_q   <= '0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         m_tdata_q     <= m_tdata_d;
         m_tkeep_q     <= m_tkeep_d;
         m_tuser_q     <= m_tuser_d;
         m_tvalid_q    <= m_tvalid_d;
         m_tlast_q     <= m_tlast_d;
         pkt_cnt_0_q   <= pkt_cnt_0_d;
         pkt_cnt_1_q   <= pkt_cnt_1_d;
      end
   end

   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tkeep  = m_tkeep_q;
   assign m_axis_tuser  = m_tuser_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tlast  = m_tlast_q;
   assign pkt_cnt_0     = pkt_cnt_0_q;
   assign pkt_cnt_1     = pkt_cnt_1_q;
   assign cur_grant     = state_q;

endmodule

// File: tb/tb_rmt_path_arbiter.sv
// Directed bench for rmt_path_arbiter: per-port beat queues feed the slaves, and master beats are logged and compared.
// Inputs are driven just after the falling edge and sampled one step later, well away from the rising edge.
module tb_rmt_path_arbiter;
   localparam int DW = 32;
   localparam int KW = DW / 8;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
   logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
   logic [TW-1:0] s0_tuser, s1_tuser, m_tuser;
   logic          s0_tvalid, s1_tvalid, m_tvalid;
   logic          s0_tlast, s1_tlast, m_tlast;
   logic          s0_tready, s1_tready, m_tready;
   logic [31:0]   pkt_cnt_0, pkt_cnt_1;
   logic [1:0]    cur_grant;

   always #5 clk = ~clk;

   rmt_path_arbiter #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(TW)) dut (
      .clk(clk), .rst(rst),
      .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tuser(s0_tuser),
      .s0_axis_tvalid(s0_tvalid), .s0_axis_tlast(s0_tlast), .s0_axis_tready(s0_tready),
      .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tuser(s1_tuser),
      .s1_axis_tvalid(s1_tvalid), .s1_axis_tlast(s1_tlast), .s1_axis_tready(s1_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .cur_grant(cur_grant)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [31:0] q0_d[$], q1_d[$], o_d[$];
   bit          q0_l[$], q1_l[$], o_l[$];
   int          o_c[$];
   int          idx0, idx1;
   bit          en0, en1;

   function automatic logic [31:0] mkd(input int port, input int pkt, input int beat);
      return 32'h1000_0000 | (32'(port) << 16) | (32'(pkt) << 8) | 32'(beat);
   endfunction

   function automatic logic [KW-1:0] keep_of(input logic [31:0] d);
      return d[3:0] ^ 4'hF;
   endfunction

   function automatic logic [TW-1:0] user_of(input logic [31:0] d);
      return d[15:0] ^ 16'h5A5A;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic upd();
      s0_tvalid = en0 && (idx0 < q0_d.size());
      s0_tdata  = s0_tvalid ? q0_d[idx0] : 32'h0;
      s0_tlast  = s0_tvalid ? q0_l[idx0] : 1'b0;
      s0_tkeep  = keep_of(s0_tdata);
      s0_tuser  = user_of(s0_tdata);
      s1_tvalid = en1 && (idx1 < q1_d.size());
      s1_tdata  = s1_tvalid ? q1_d[idx1] : 32'h0;
      s1_tlast  = s1_tvalid ? q1_l[idx1] : 1'b0;
      s1_tkeep  = keep_of(s1_tdata);
      s1_tuser  = user_of(s1_tdata);
      #1;
   endtask

   // Sample what the next rising edge will transfer, step one cycle, re-drive.
   task automatic tick();
      bit a0, a1;
      a0 = s0_tvalid && s0_tready;
      a1 = s1_tvalid && s1_tready;
      if (m_tvalid && m_tready) begin
         o_d.push_back(m_tdata);
         o_l.push_back(m_tlast);
         o_c.push_back(cyc);
         chk("tkeep_pass", m_tkeep, keep_of(m_tdata));
         chk("tuser_pass", m_tuser, user_of(m_tdata));
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (a0) idx0++;
      if (a1) idx1++;
      upd();
   endtask

   task automatic add_pkt(input int port, input int pkt, input int n);
      for (int b = 0; b < n; b++) begin
         if (port == 0) begin
            q0_d.push_back(mkd(0, pkt, b));
            q0_l.push_back(b == n - 1);
         end else begin
            q1_d.push_back(mkd(1, pkt, b));
            q1_l.push_back(b == n - 1);
         end
      end
   endtask

   task automatic clr();
      q0_d.delete(); q0_l.delete(); q1_d.delete(); q1_l.delete();
      o_d.delete(); o_l.delete(); o_c.delete();
      idx0 = 0; idx1 = 0; en0 = 1'b0; en1 = 1'b0;
      upd();
   endtask

   task automatic run_until(input string tag, input int n_out, input int budget);
      int b;
      b = 0;
      while (o_d.size() < n_out && b < budget) begin
         tick();
         b++;
      end
      chk(tag, o_d.size(), n_out);
   endtask

   task automatic wait_idx0(input string tag, input int n);
      int b;
      b = 0;
      while (idx0 < n && b < 30) begin
         tick();
         b++;
      end
      chk(tag, idx0, n);
   endtask

   initial begin
      m_tready = 1'b1;
      @(negedge clk);
      // Reset with both ports presenting data: neither may be accepted.
      clr();
      add_pkt(0, 15, 1); add_pkt(1, 15, 1);
      en0 = 1'b1; en1 = 1'b1;
      upd();
      repeat (3) tick();
      chk("rst_s0_tready", s0_tready, 1'b0);
      chk("rst_s1_tready", s1_tready, 1'b0);
      chk("rst_m_tvalid", m_tvalid, 1'b0);
      chk("rst_m_tlast", m_tlast, 1'b0);
      chk("rst_m_tdata", m_tdata, 32'h0);
      chk("rst_m_tkeep", m_tkeep, 4'h0);
      chk("rst_m_tuser", m_tuser, 16'h0);
      chk("rst_cnt0", pkt_cnt_0, 32'h0);
      chk("rst_cnt1", pkt_cnt_1, 32'h0);
      chk("rst_grant", cur_grant, 2'b00);
      clr();
      rst = 1'b0;
      upd();

      // Both ports busy with 3-beat packets: P0,P1,P0,P1 with one bubble between packets.
      add_pkt(0, 0, 3); add_pkt(1, 0, 3); add_pkt(0, 1, 3); add_pkt(1, 1, 3);
      en0 = 1'b1; en1 = 1'b1;
      upd();
      run_until("alt_count", 12, 80);
      for (int i = 0; i < 12; i++) begin
         if (i < o_d.size()) begin
            chk("alt_data", o_d[i], mkd((i / 3) % 2, i / 6, i % 3));
            chk("alt_last", o_l[i], (i % 3) == 2);
         end
      end
      if (o_c.size() == 12) begin
         chk("alt_gap1", o_c[3] - o_c[2], 2);
         chk("alt_gap2", o_c[6] - o_c[5], 2);
         chk("alt_gap3", o_c[9] - o_c[8], 2);
         chk("alt_span", o_c[11] - o_c[0], 14);
      end
      tick();
      chk("alt_cnt0", pkt_cnt_0, 32'd2);
      chk("alt_cnt1", pkt_cnt_1, 32'd2);
      clr();

      // Port 1 alone, single-beat packets: one beat every second cycle.
      for (int k = 0; k < 3; k++) add_pkt(1, 2 + k, 1);
      en1 = 1'b1;
      upd();
      run_until("one_count", 3, 30);
      for (int i = 0; i < 3; i++) begin
         if (i < o_d.size()) begin
            chk("one_data", o_d[i], mkd(1, 2 + i, 0));
            chk("one_last", o_l[i], 1'b1);
         end
      end
      if (o_c.size() == 3) begin
         chk("one_rate1", o_c[1] - o_c[0], 2);
         chk("one_rate2", o_c[2] - o_c[1], 2);
      end
      chk("one_cnt1", pkt_cnt_1, 32'd5);
      clr();

      // Downstream stall for 3 cycles in the middle of a 4-beat port 0 packet.
      add_pkt(0, 4, 4);
      en0 = 1'b1;
      upd();
      wait_idx0("stall_reach", 2);
      m_tready = 1'b0;
      upd();
      for (int i = 0; i < 3; i++) begin
         chk("stall_s0_tready", s0_tready, 1'b0);
         chk("stall_m_tvalid", m_tvalid, 1'b1);
         chk("stall_m_tdata", m_tdata, mkd(0, 4, 1));
         tick();
      end
      chk("stall_m_tdata_end", m_tdata, mkd(0, 4, 1));
      m_tready = 1'b1;
      upd();
      run_until("stall_count", 4, 20);
      for (int i = 0; i < 4; i++)
         if (i < o_d.size()) chk("stall_data", o_d[i], mkd(0, 4, i));
      repeat (2) tick();
      chk("stall_extra", o_d.size(), 4);
      chk("stall_cnt0", pkt_cnt_0, 32'd3);
      clr();

      // Port 0 pauses mid-packet while port 1 waits; the grant must hold.
      add_pkt(0, 5, 4); add_pkt(1, 5, 2);
      en0 = 1'b1;
      upd();
      tick();
      en1 = 1'b1;
      upd();
      wait_idx0("pause_reach", 2);
      en0 = 1'b0;
      upd();
      for (int i = 0; i < 2; i++) begin
         chk("pause_s1_tready", s1_tready, 1'b0);
         chk("pause_grant", cur_grant, 2'b01);
         tick();
      end
      en0 = 1'b1;
      upd();
      run_until("pause_count", 6, 40);
      for (int i = 0; i < 6; i++)
         if (i < o_d.size()) chk("pause_data", o_d[i], (i < 4) ? mkd(0, 5, i) : mkd(1, 5, i - 4));
      chk("pause_cnt0", pkt_cnt_0, 32'd4);
      chk("pause_cnt1", pkt_cnt_1, 32'd6);
      chk("pause_grant_idle", cur_grant, 2'b00);
      clr();

      // Counter wrap from all-ones.
      force dut.pkt_cnt_0_q = 32'hFFFF_FFFF;
      tick();
      release dut.pkt_cnt_0_q;
      #1;
      chk("wrap_pre", pkt_cnt_0, 32'hFFFF_FFFF);
      add_pkt(0, 6, 1);
      en0 = 1'b1;
      upd();
      run_until("wrap_count", 1, 20);
      chk("wrap_cnt0", pkt_cnt_0, 32'h0);
      chk("wrap_cnt1", pkt_cnt_1, 32'd6);
      clr();

      // Reset while beat 2 of a 5-beat packet is offered, then a fresh packet.
      add_pkt(0, 7, 5);
      en0 = 1'b1;
      upd();
      wait_idx0("mrst_reach", 2);
      rst = 1'b1;
      upd();
      chk("mrst_s0_tready_in", s0_tready, 1'b0);
      tick();
      chk("mrst_m_tvalid", m_tvalid, 1'b0);
      chk("mrst_m_tlast", m_tlast, 1'b0);
      chk("mrst_m_tdata", m_tdata, 32'h0);
      chk("mrst_m_tkeep", m_tkeep, 4'h0);
      chk("mrst_m_tuser", m_tuser, 16'h0);
      chk("mrst_cnt0", pkt_cnt_0, 32'h0);
      chk("mrst_cnt1", pkt_cnt_1, 32'h0);
      chk("mrst_grant", cur_grant, 2'b00);
      chk("mrst_s0_tready", s0_tready, 1'b0);
      rst = 1'b0;
      q0_d.delete(); q0_l.delete(); idx0 = 0;
      add_pkt(0, 8, 2);
      upd();
      run_until("mrst_count", 4, 30);
      for (int i = 0; i < 4; i++)
         if (i < o_d.size()) chk("mrst_data", o_d[i], (i < 2) ? mkd(0, 7, i) : mkd(0, 8, i - 2));
      if (o_l.size() == 4) begin
         chk("mrst_last_old", o_l[1], 1'b0);
         chk("mrst_last_new", o_l[3], 1'b1);
      end
      chk("mrst_cnt0_after", pkt_cnt_0, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
